// File: rtl/multiprecision_add_pkg.sv
// rtl/multiprecision_add_pkg.sv - shared types and helpers for the multiprecision add sequencer
package multiprecision_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter width for a slice index; never narrower than one bit so K=1 still has a counter.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/StructuralCarrySkipAdder.sv
// rtl/StructuralCarrySkipAdder.sv - N-bit carry-skip adder built from 4-bit ripple blocks
module StructuralCarrySkipAdder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  output logic [N-1:0] c,
  output logic         carry_out
);

  localparam int BS = 4;

  logic carry;
  logic blk_cin;
  logic blk_p;
  logic p;

  // Ripple inside each block; a fully-propagating block forwards its incoming carry directly.
  always_comb begin
    c       = '0;
    carry   = carry_in;
    blk_cin = carry_in;
    blk_p   = 1'b1;
    p       = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (j % BS == 0) begin
        blk_cin = carry;
        blk_p   = 1'b1;
      end
      p     = a[j] ^ b[j];
      c[j]  = p ^ carry;
      carry = (a[j] & b[j]) | (p & carry);
      blk_p = blk_p & p;
      if ((j % BS == BS - 1) || (j == N - 1)) begin
        carry = blk_p ? blk_cin : carry;
      end
    end
    carry_out = carry;
  end

endmodule

// File: rtl/multiprecision_add_sequencer.sv
// rtl/multiprecision_add_sequencer.sv - W=N*K bit adder that reuses one N-bit adder over K cycles
module multiprecision_add_sequencer
  import multiprecision_add_pkg::*;
#(
  parameter int N = 32,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*K-1:0] in_a,
  input  logic [N*K-1:0] in_b,
  input  logic           in_carry,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*K-1:0] out_c,
  output logic           out_carry,
  output logic           out_ovf,
  output logic           busy
);

  localparam int CW = clog2(K);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  cr_q, cr_d;
  logic [K-1:0][N-1:0]   a_q, a_d;
  logic [K-1:0][N-1:0]   b_q, b_d;
  logic [K-1:0][N-1:0]   res_q, res_d;

  logic [N-1:0]          slice_sum;
  logic                  slice_co;
  logic                  last_slice;
  logic                  done;

  StructuralCarrySkipAdder #(.N(N)) u_adder (
    .a         (a_q[cnt_q]),
    .b         (b_q[cnt_q]),
    .carry_in  (cr_q),
    .c         (slice_sum),
    .carry_out (slice_co)
  );

  assign last_slice = (cnt_q == CW'(K - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cr_d    = cr_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          cr_d    = in_carry;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[cnt_q] = slice_sum;
        cr_d         = slice_co;
        // The counter parks on the last slice so it never indexes past K-1.
        if (last_slice) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cr_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cr_q    <= cr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign done      = (state_q == DONE);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = done;
  assign busy      = (state_q != IDLE);

  // Result outputs read zero outside DONE so a partially built sum is never visible.
  assign out_c     = done ? res_q : '0;
  assign out_carry = done & cr_q;
  assign out_ovf   = done & (a_q[K-1][N-1] == b_q[K-1][N-1]) & (res_q[K-1][N-1] != a_q[K-1][N-1]);

endmodule

// File: tb/tb_multiprecision_add_sequencer.sv
// tb/tb_multiprecision_add_sequencer.sv - scoreboard bench for multiprecision_add_sequencer
module tb_multiprecision_add_sequencer;

  localparam int N = 32;
  localparam int K = 4;
  localparam int W = N * K;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_ready, in_carry;
  logic [W-1:0] in_a, in_b, out_c;
  logic         out_valid, out_ready, out_carry, out_ovf, busy;

  logic         k1_in_valid, k1_in_ready, k1_in_carry;
  logic [7:0]   k1_in_a, k1_in_b, k1_out_c;
  logic         k1_out_valid, k1_out_ready, k1_out_carry, k1_out_ovf, k1_busy;

  multiprecision_add_sequencer #(.N(N), .K(K)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .out_carry(out_carry),
    .out_ovf(out_ovf), .busy(busy)
  );

  multiprecision_add_sequencer #(.N(8), .K(1)) dut_k1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(k1_in_valid), .in_ready(k1_in_ready), .in_a(k1_in_a), .in_b(k1_in_b),
    .in_carry(k1_in_carry),
    .out_valid(k1_out_valid), .out_ready(k1_out_ready), .out_c(k1_out_c),
    .out_carry(k1_out_carry), .out_ovf(k1_out_ovf), .busy(k1_busy)
  );

  typedef struct {
    logic [W-1:0] c;
    logic         carry;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input int acc);
    exp_t     e;
    logic [W:0] s;
    s       = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    e.c     = s[W-1:0];
    e.carry = s[W];
    e.ovf   = (a[W-1] == b[W-1]) && (e.c[W-1] != a[W-1]);
    e.acc   = acc;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 5))
      0:       v = '1;
      1:       v = '0;
      2:       v = {1'b0, {(W-1){1'b1}}};
      3:       v = {1'b1, {(W-1){1'b0}}};
      default: ;
    endcase
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  W'(in_ready),  W'(1));
    check({tag, "_out_valid"}, W'(out_valid), W'(0));
    check({tag, "_busy"},      W'(busy),      W'(0));
    check({tag, "_out_c"},     out_c,         '0);
    check({tag, "_out_carry"}, W'(out_carry), W'(0));
    check({tag, "_out_ovf"},   W'(out_ovf),   W'(0));
  endtask

  // Monitor: pops the scoreboard on every output handshake and watches the protocol.
  initial begin
    logic [W-1:0] hc;
    logic         hcar, hovf, prev_ov, prev_or;
    prev_ov = 1'b0;
    prev_or = 1'b0;
    hc = '0; hcar = 1'b0; hovf = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_ov = 1'b0;
        prev_or = 1'b0;
        continue;
      end
      check("busy_vs_in_ready", W'(busy), W'(!in_ready));
      check("ready_valid_exclusive", W'(in_ready & out_valid), W'(0));
      if (out_valid && prev_ov && !prev_or) begin
        check("hold_out_c", out_c, hc);
        check("hold_out_carry", W'(out_carry), W'(hcar));
        check("hold_out_ovf", W'(out_ovf), W'(hovf));
      end
      if (out_valid && !prev_ov) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL stale_out_valid actual=1 required=0");
        end else begin
          check("latency_edges", W'(cyc - exp_q[0].acc), W'(K + 1));
        end
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        check("out_c", out_c, exp_q[0].c);
        check("out_carry", W'(out_carry), W'(exp_q[0].carry));
        check("out_ovf", W'(out_ovf), W'(exp_q[0].ovf));
        void'(exp_q.pop_front());
      end
      prev_ov = out_valid;
      prev_or = out_ready;
      hc = out_c; hcar = out_carry; hovf = out_ovf;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int t;
    in_a = a; in_b = b; in_carry = cin; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(a, b, cin, cyc));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic k1_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic [7:0] ec, input logic ecar, input logic eovf);
    int t0, t;
    k1_in_a = a; k1_in_b = b; k1_in_carry = cin; k1_in_valid = 1'b1;
    check("k1_in_ready", W'(k1_in_ready), W'(1));
    t0 = cyc;
    @(negedge clk);
    k1_in_valid = 1'b0;
    t = 0;
    while (!k1_out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("k1_latency_edges", W'(cyc - t0), W'(2));
    check("k1_out_c", W'(k1_out_c), W'(ec));
    check("k1_out_carry", W'(k1_out_carry), W'(ecar));
    check("k1_out_ovf", W'(k1_out_ovf), W'(eovf));
    @(negedge clk);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, guard;
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_carry = 1'b0; out_ready = 1'b1;
    k1_in_valid = 1'b0; k1_in_a = '0; k1_in_b = '0; k1_in_carry = 1'b0; k1_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    send('1, '0, 1'b1);
    drain();
    send({1'b0, {(W-1){1'b1}}}, W'(1), 1'b0);
    drain();

    // Stall in DONE with live, changing input traffic.
    out_ready = 1'b0;
    send(rnd(), rnd(), 1'($urandom));
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_a = rnd(); in_b = rnd(); in_carry = 1'($urandom);
      @(negedge clk);
      check("stall_in_ready", W'(in_ready), W'(0));
      check("stall_out_valid", W'(out_valid), W'(1));
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("release_in_ready", W'(in_ready), W'(1));
    check("release_no_accept", W'(exp_q.size()), W'(0));

    // Reset landing on the second RUN cycle.
    send(rnd(), rnd(), 1'($urandom));
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_vals("midrun_reset");
    send(rnd(), rnd(), 1'($urandom));
    drain();

    acc = 0;
    guard = 0;
    while (acc < 1200 && guard < 40000) begin
      in_valid = ($urandom % 3) != 0;
      in_a = rnd(); in_b = rnd(); in_carry = 1'($urandom);
      out_ready = ($urandom % 4) != 0;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_a, in_b, in_carry, cyc));
        acc++;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("random_ops_accepted", W'(acc), W'(1200));
    drain();

    k1_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    k1_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
